// File: rtl/alu_arbiter_if.sv
// ============================================================================
// alu_arbiter_if : request/response channels of both requesters and ALU bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface alu_arbiter_if #(
    parameter int WIDTH = 64
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_ctrl;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_ctrl;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_result;
    logic             rsp0_zero;
    logic             rsp0_err;

    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_result;
    logic             rsp1_zero;
    logic             rsp1_err;

    logic [WIDTH-1:0] BusA;
    logic [WIDTH-1:0] BusB;
    logic [3:0]       ALUCtrl;
    logic [WIDTH-1:0] BusW;
    logic             Zero;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        output req1_ready,
        output rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
        input  rsp0_ready,
        output rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
        input  rsp1_ready,
        output BusA, BusB, ALUCtrl,
        input  BusW, Zero
    );

    // Requesters and ALU side
    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        input  req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
        output rsp0_ready,
        input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
        output rsp1_ready,
        input  BusA, BusB, ALUCtrl,
        output BusW, Zero
    );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter : round-robin sequencer sharing one combinational ALU between two requesters
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int WIDTH       = 64,
    parameter int EXEC_CYCLES = 1
) (
    input  logic          CLK,
    input  logic          Reset_L,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_t           state_q;
    logic             grant_q;
    logic             last_grant_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] bus_a_q;
    logic [WIDTH-1:0] bus_b_q;
    logic [3:0]       ctrl_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             err_q;
    logic [1:0]       rsp_valid_q;

    logic             winner;
    logic             accept;
    logic             legal;
    logic             rsp_ready_g;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [3:0]       sel_ctrl;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            4'h0, 4'h1, 4'h2, 4'h6, 4'h7: is_legal = 1'b1;
            default:                      is_legal = 1'b0;
        endcase
    endfunction

    // Under conflict the requester that was not served last wins.
    always_comb begin
        winner = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            winner = ~last_grant_q;
        end else if (bus.req1_valid) begin
            winner = 1'b1;
        end
    end

    assign bus.req0_ready = Reset_L && (state_q == IDLE) && !winner && bus.req0_valid;
    assign bus.req1_ready = Reset_L && (state_q == IDLE) &&  winner && bus.req1_valid;
    assign accept         = bus.req0_ready | bus.req1_ready;

    assign sel_a       = winner ? bus.req1_a    : bus.req0_a;
    assign sel_b       = winner ? bus.req1_b    : bus.req0_b;
    assign sel_ctrl    = winner ? bus.req1_ctrl : bus.req0_ctrl;
    assign legal       = is_legal(sel_ctrl);
    assign rsp_ready_g = grant_q ? bus.rsp1_ready : bus.rsp0_ready;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            bus_a_q      <= '0;
            bus_b_q      <= '0;
            ctrl_q       <= 4'd0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
            rsp_valid_q  <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        grant_q <= winner;
                        if (legal) begin
                            bus_a_q <= sel_a;
                            bus_b_q <= sel_b;
                            ctrl_q  <= sel_ctrl;
                            cnt_q   <= EXEC_LOAD;
                            state_q <= EXEC;
                        end else begin
                            // Illegal opcodes never reach the ALU.
                            result_q            <= '0;
                            zero_q              <= 1'b0;
                            err_q               <= 1'b1;
                            rsp_valid_q[winner] <= 1'b1;
                            state_q             <= RESP;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_q == 4'd0) begin
                        result_q             <= bus.BusW;
                        zero_q               <= bus.Zero;
                        err_q                <= 1'b0;
                        rsp_valid_q[grant_q] <= 1'b1;
                        state_q              <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_valid_q[grant_q] && rsp_ready_g) begin
                        rsp_valid_q  <= 2'b00;
                        last_grant_q <= grant_q;
                        bus_a_q      <= '0;
                        bus_b_q      <= '0;
                        ctrl_q       <= 4'd0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.BusA        = bus_a_q;
    assign bus.BusB        = bus_b_q;
    assign bus.ALUCtrl     = ctrl_q;

    assign bus.rsp0_valid  = rsp_valid_q[0];
    assign bus.rsp0_result = result_q;
    assign bus.rsp0_zero   = zero_q;
    assign bus.rsp0_err    = err_q;
    assign bus.rsp1_valid  = rsp_valid_q[1];
    assign bus.rsp1_result = result_q;
    assign bus.rsp1_zero   = zero_q;
    assign bus.rsp1_err    = err_q;

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Sequencer and arbiter that shares one 64-bit combinational ALU between two requesters.
- Each requester has a valid/ready request channel: operands plus a 4-bit ALUCtrl opcode.
- Each requester also has a valid/ready response channel: result, Zero flag and error flag.
- The block sits between the register-read stage clients and the ALU instance. It drives BusA/BusB/ALUCtrl and samples BusW/Zero after a programmable settle time.

Parameters:
- WIDTH, 64: datapath width of operands and result.
- EXEC_CYCLES, 1: cycles the ALU inputs are held before BusW/Zero are sampled. Legal range 1..15.

Ports:
- CLK  in  1  rising-edge clock
- Reset_L  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  WIDTH  requester 0 operand A
- req0_b  in  WIDTH  requester 0 operand B
- req0_ctrl  in  4  requester 0 opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl: same as requester 0, for requester 1
- rsp0_valid  out  1  response pending for requester 0
- rsp0_ready  in  1  requester 0 takes the response
- rsp0_result  out  WIDTH  captured BusW
- rsp0_zero  out  1  captured Zero
- rsp0_err  out  1  illegal opcode
- rsp1_valid, rsp1_ready, rsp1_result, rsp1_zero, rsp1_err: same as requester 0, for requester 1
- BusA  out  WIDTH  to ALU
- BusB  out  WIDTH  to ALU
- ALUCtrl  out  4  to ALU
- BusW  in  WIDTH  from ALU
- Zero  in  1  from ALU

Behaviour:
- Opcode encoding:
  - AND=4'h0, OR=4'h1, ADD=4'h2, SUB=4'h6, PASSB=4'h7.
  - Every other value is illegal.
- Reset (Reset_L=0, asynchronous):
  - State goes to IDLE.
  - Every output goes to 0: ready, rsp_valid, result, zero, err, BusA, BusB, ALUCtrl.
  - last_grant goes to 1, so requester 0 wins the first conflict.
  - Any in-flight operation is dropped and no response is ever produced for it.
- State machine, states IDLE, EXEC, RESP:
  - IDLE:
    - Pick a winner. If only one req_valid is high, it wins. If both are high, the requester not equal to last_grant wins.
    - reqN_ready is combinational and equals (state==IDLE && winner==N && reqN_valid). At most one ready is high.
    - On handshake, register a, b, ctrl and the grant index.
    - Legal ctrl: go to EXEC and load exec counter = EXEC_CYCLES-1.
    - Illegal ctrl: go directly to RESP with result=0, zero=0, err=1. The ALU is not driven.
  - EXEC:
    - BusA/BusB/ALUCtrl are driven from the registered operands and are held stable the whole state.
    - The counter decrements each cycle.
    - In the cycle where counter==0, capture BusW/Zero into the response registers, set err=0, and go to RESP.
  - RESP:
    - rspG_valid=1 for the granted requester only. Result, zero and err are held stable.
    - On rspG_valid && rspG_ready: deassert valid, set last_grant=G, go to IDLE.
    - No new request is accepted in RESP; ready stays 0.
- ALU outputs:
  - BusA/BusB/ALUCtrl are 0 in IDLE.
  - In RESP they keep the EXEC values.
- Response outputs:
  - The non-granted requester's rsp_valid stays 0.
  - Result/zero/err registers keep their last value when valid is low. Benches check them only while valid is high.
- Latency:
  - Handshake at cycle N.
  - EXEC occupies cycles N+1 .. N+EXEC_CYCLES.
  - rsp_valid is first high at N+EXEC_CYCLES+1.
  - Illegal-opcode response is first high at N+1.
  - Best-case throughput is one op per EXEC_CYCLES+2 cycles when rsp_ready is held high.
- Boundary conditions:
  - A request whose valid drops before ready is simply not taken. Requesters must hold valid and data until ready.
  - rsp_ready high with no valid has no effect.
  - Back-to-back requests from the same requester while the other requester is idle are all served.
  - Round-robin fairness is guaranteed only under conflict.

Test Plan:
- Reset, then req0 {a=64'h1234, b=64'hABCD0000, ctrl=2}, EXEC_CYCLES=1, rsp0_ready=1:
  - req0_ready is high in the accept cycle.
  - rsp0_valid is high 2 cycles later with result=64'hABCD1234, zero=0, err=0.
- req1 {a=64'hFFFFFFFF, b=64'hFFFFFFFF, ctrl=6} -> rsp1 result=0, zero=1. Then req1 {64'h80000001, 64'h7FFFFFFF, 6} -> result=64'h2, zero=0.
- Both valid from reset, held continuously:
  - Requester 0 is served first, then requester 1, then requester 0 again.
  - Operations used: req0 AND {64'hABCDEF01, 64'hFEDCBA98} -> 64'hAACCAA00; req1 OR {64'hAABBCCDD, 64'hBBAADDCC} -> 64'hBBBBDDDD.
- Backpressure: PASSB {64'h87654321, 64'hABCDEF01, 7} with rsp0_ready=0 for 5 cycles:
  - rsp0_valid stays high and result stays 64'hABCDEF01.
  - req1_ready stays 0 throughout, with req1_valid=1.
- Illegal ctrl=4'h3 on req0 -> rsp0_valid one cycle after accept, err=1, result=0, zero=0, ALUCtrl remains 0.
- EXEC_CYCLES=4 ADD {64'hABABABAB, 64'hCDCDCDCD}:
  - ALU inputs are held stable for 4 cycles.
  - Result is 64'h179797978.
  - Assert Reset_L=0 mid-EXEC on a second run: all outputs go to 0 immediately and no response appears after release.
